mem_stage_access_unit: RTL and testbench

Memory-stage access unit of the 5-stage RISC-V core, directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM control and data fields, resolves the branch/jump redirect, and performs loads and stores against the data memory over a req/ack handshake. It stalls the pipeline while an access is outstanding and delivers sign- or zero-extended load data and a valid strobe toward MEM/WB.

---
 rtl/mem_stage_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage_access_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_unit.sv
// MEM-stage load/store unit: redirect resolve, req/ack data-memory access, load extension.
// Latency 1 cycle for non-memory ops, 2+N for a memory op acked after N waits; stalls upstream while the access is open.
// MEM_MISALIGN_TRAP_EN: defined traps misaligned/illegal ops without touching memory; undefined forces natural alignment.
module mem_stage_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        branch_in,
  input  logic        force_jump_in,
  input  logic        zero_in,
  input  logic [31:0] jump_pc_in,
  input  logic [2:0]  instruction_func_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  output logic        pc_src_out,
  output logic [31:0] jump_pc_out,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] read_data_out,
  output logic        misaligned_out,
  output logic        bus_error_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             we_q;
  logic [1:0]       size_q;
  logic [1:0]       lane_q;
  logic             unsigned_q;
  logic             valid_q;
  logic [31:0]      rdata_q;

  logic        is_mem;
  logic        bad_f3;
  logic [1:0]  size_eff;
  logic [31:0] addr_nat;
  logic [1:0]  lane;
  logic [3:0]  be_nat;
  logic [31:0] wdata_nat;
  logic        trap;
  logic        accept;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign pc_src_out  = valid_in & (force_jump_in | (branch_in & zero_in));
  assign jump_pc_out = jump_pc_in;

  assign is_mem = valid_in & (mem_read_in | mem_write_in);
  // Unsigned variants exist only for byte/half loads; anything else with funct3[2] set is illegal.
  assign bad_f3 = (instruction_func_in[1:0] == 2'b11) |
                  (instruction_func_in[2] & ((instruction_func_in[1:0] == 2'b10) | mem_write_in));
  assign size_eff = bad_f3 ? 2'b10 : instruction_func_in[1:0];

  always_comb begin
    addr_nat  = alu_result_in;
    be_nat    = 4'b1111;
    wdata_nat = write_data_in;
    case (size_eff)
      2'b00: addr_nat = alu_result_in;
      2'b01: addr_nat = {alu_result_in[31:1], 1'b0};
      default: addr_nat = {alu_result_in[31:2], 2'b00};
    endcase
    case (size_eff)
      2'b00: begin
        be_nat    = 4'b0001 << lane;
        wdata_nat = {4{write_data_in[7:0]}};
      end
      2'b01: begin
        be_nat    = 4'b0011 << lane;
        wdata_nat = {2{write_data_in[15:0]}};
      end
      default: begin
        be_nat    = 4'b1111;
        wdata_nat = write_data_in;
      end
    endcase
  end

  assign lane = addr_nat[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  // An access is misaligned exactly when natural alignment would have moved its address.
  assign trap = is_mem & (bad_f3 | (mem_read_in & mem_write_in) | (addr_nat != alu_result_in));
`else
  assign trap = 1'b0;
`endif

  assign accept = (state == ST_IDLE) & ~reset & is_mem & ~trap;

  assign shifted = dmem_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_ext = dmem_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      lane_q     <= '0;
      unsigned_q <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q     <= {addr_nat[31:2], 2'b00};
            lane_q     <= lane;
            be_q       <= be_nat;
            wdata_q    <= wdata_nat;
            we_q       <= mem_write_in & ~mem_read_in;
            size_q     <= size_eff;
            unsigned_q <= instruction_func_in[2];
            wait_cnt   <= '0;
            state      <= ST_ACCESS;
          end else if (valid_in) begin
            valid_q <= 1'b1;
            rdata_q <= '0;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            valid_q <= 1'b1;
            rdata_q <= we_q ? 32'd0 : load_ext;
            state   <= ST_IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= (state == ST_IDLE) & trap;
    end
  end
  assign misaligned_out = mis_q;
`else
  assign misaligned_out = 1'b0;
`endif

  assign dmem_req      = (state == ST_ACCESS);
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign stall_out     = accept | ((state == ST_ACCESS) & ~dmem_ack) | (state == ST_ERROR);
  assign bus_error_out = (state == ST_ERROR);
  assign valid_out     = valid_q;
  assign read_data_out = rdata_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed ops, an arithmetic reference model with an expectation queue,
// and a per-cycle compare process.
module tb_mem_stage_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, mem_read_in, mem_write_in, branch_in, force_jump_in, zero_in;
  logic [31:0] jump_pc_in, alu_result_in, write_data_in;
  logic [2:0]  instruction_func_in;
  logic        pc_src_out, stall_out, valid_out, misaligned_out, bus_error_out;
  logic [31:0] jump_pc_out, read_data_out;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  always #5 clk = ~clk;

  mem_stage_access_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .branch_in(branch_in), .force_jump_in(force_jump_in),
    .zero_in(zero_in), .jump_pc_in(jump_pc_in), .instruction_func_in(instruction_func_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .pc_src_out(pc_src_out),
    .jump_pc_out(jump_pc_out), .stall_out(stall_out), .valid_out(valid_out),
    .read_data_out(read_data_out), .misaligned_out(misaligned_out), .bus_error_out(bus_error_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic        trap;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          size;
    int          lane;
    logic        sgn;
  } req_m_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t   expq[$];
  req_m_t cur_m;

  // Reference: access size in bytes, natural alignment by modulo, lanes by byte index.
  function automatic req_m_t model_req(input logic rd, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd);
    req_m_t m;
    logic   legal_f3;
    int     sz;
    logic [31:0] al;
    legal_f3 = (f3[1:0] != 2'b11) && !(f3[2] && (f3[1:0] == 2'b10)) && !(wr && f3[2]);
    sz = legal_f3 ? (1 << f3[1:0]) : 4;
    m.trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    m.trap = !legal_f3 || (rd && wr) || ((a % sz) != 0);
`endif
    al     = a - (a % sz);
    m.lane = int'(al % 4);
    m.addr = al - m.lane;
    m.be   = 4'(((1 << sz) - 1) << m.lane);
    for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
    m.we   = wr && !rd;
    m.size = sz;
    m.sgn  = !f3[2];
    return m;
  endfunction

  function automatic logic [31:0] model_load(input req_m_t m, input logic [31:0] w);
    longint v;
    if (m.size == 4) return w;
    v = longint'(w >> (8 * m.lane)) % (longint'(1) << (8 * m.size));
    if (m.sgn && v >= (longint'(1) << (8 * m.size - 1))) v = v - (longint'(1) << (8 * m.size));
    return 32'(v);
  endfunction

  // Memory responder: acks after ack_wait request cycles unless hung.
  int          ack_wait = 0;
  logic        hang = 1'b0;
  logic        late_ack = 1'b0;
  logic [31:0] mem_word = '0;
  initial begin
    int wc;
    wc = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (late_ack) begin
        dmem_ack = 1'b1;
      end else if (dmem_req && !hang) begin
        if (wc == ack_wait) begin
          dmem_ack = 1'b1;
          dmem_rdata = mem_word;
          wc = 0;
        end else begin
          dmem_ack = 1'b0;
          wc++;
        end
      end else begin
        dmem_ack = 1'b0;
        wc = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  int          req_seen = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("pc_src", {31'b0, pc_src_out}, {31'b0, valid_in & (force_jump_in | (branch_in & zero_in))});
      chk("jump_pc", jump_pc_out, jump_pc_in);
      if (dmem_req) begin
        req_seen++;
        cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
        chk("req_trap", {31'b0, cur_m.trap}, 32'd0);
        chk("req_addr", dmem_addr, cur_m.addr);
        chk("req_be", {28'b0, dmem_be}, {28'b0, cur_m.be});
        chk("req_we", {31'b0, dmem_we}, {31'b0, cur_m.we});
        if (cur_m.we) chk("req_wdata", dmem_wdata, cur_m.wdata);
      end
      if (valid_out) begin
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: valid_out=1 at cycle %0d, none expected", cyc);
        end else begin
          e = expq.pop_front();
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
          chk("read_data", read_data_out, e.data);
          chk("misaligned", {31'b0, misaligned_out}, {31'b0, e.mis});
        end
      end
    end
  end

  task automatic clear_inputs();
    valid_in = 0; mem_read_in = 0; mem_write_in = 0; branch_in = 0;
    force_jump_in = 0; zero_in = 0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic fj, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] jpc,
                       input int wt, input logic [31:0] word, output int stalls);
    req_m_t m;
    exp_t   e;
    logic   mem;
    mem = rd | wr;
    m = model_req(rd, wr, f3, a, wd);
    @(posedge clk);
    #1;
    cur_m = m; ack_wait = wt; mem_word = word;
    valid_in = 1; mem_read_in = rd; mem_write_in = wr; force_jump_in = fj;
    instruction_func_in = f3; alu_result_in = a; write_data_in = wd; jump_pc_in = jpc;
    e.mis = mem & m.trap;
    if (!mem || m.trap) begin
      e.cyc = cyc + 1; e.data = '0;
    end else begin
      e.cyc = cyc + 2 + wt; e.data = m.we ? 32'd0 : model_load(m, word);
    end
    expq.push_back(e);
    stalls = 0;
    @(negedge clk);
    while (stall_out && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (stall_out) begin
      n_tests++;
      n_fail++;
      $display("FAIL stall_bound: stall_out still 1 after %0d cycles", stalls);
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic hold_load(input logic [31:0] a);
    @(posedge clk);
    #1;
    cur_m = model_req(1'b1, 1'b0, 3'b010, a, 32'd0);
    valid_in = 1; mem_read_in = 1; instruction_func_in = 3'b010; alu_result_in = a;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, valid_out}, 32'd0);
    chk({tag, "_stall"}, {31'b0, stall_out}, 32'd0);
    chk({tag, "_req"}, {31'b0, dmem_req}, 32'd0);
    chk({tag, "_rdata"}, read_data_out, 32'd0);
    chk({tag, "_buserr"}, {31'b0, bus_error_out}, 32'd0);
    chk({tag, "_mis"}, {31'b0, misaligned_out}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_be"}, {28'b0, dmem_be}, 32'd0);
    chk({tag, "_we"}, {31'b0, dmem_we}, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, r0, rq;
    clear_inputs();
    instruction_func_in = '0; alu_result_in = '0; write_data_in = '0; jump_pc_in = '0;
    cur_m = model_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    reset = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #3 reset = 0;

    // LW 0x100, two waits
    issue(1, 0, 0, 3'b010, 32'h100, 0, 0, 2, 32'hDEADBEEF, st);
    chk("lw_stalls", 32'(st), 32'd3);
    @(negedge clk);
    chk("lw_valid", {31'b0, valid_out}, 32'd1);
    chk("lw_data", read_data_out, 32'hDEADBEEF);

    // LB / LBU at 0x103, zero-wait
    issue(1, 0, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80123456, st);
    chk("lb_stalls", 32'(st), 32'd1);
    @(negedge clk);
    chk("lb_data", read_data_out, 32'hFFFFFF80);
    issue(1, 0, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80123456, st);
    @(negedge clk);
    chk("lbu_data", read_data_out, 32'h00000080);

    // SH at 0x102
    issue(0, 1, 0, 3'b001, 32'h102, 32'h1234ABCD, 0, 1, 0, st);
    chk("sh_be", {28'b0, cap_be}, 32'h0000000C);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    chk("sh_we", {31'b0, cap_we}, 32'd1);
    chk("sh_addr", cap_addr, 32'h100);

    // LW at 0x101
    r0 = req_seen;
    issue(1, 0, 0, 3'b010, 32'h101, 0, 0, 0, 32'h55667788, st);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_noreq", 32'(req_seen), 32'(r0));
    chk("mis_stalls", 32'(st), 32'd0);
    @(negedge clk);
    chk("mis_flag", {31'b0, misaligned_out}, 32'd1);
    chk("mis_data", read_data_out, 32'd0);
`else
    chk("lw101_addr", cap_addr, 32'h100);
    @(negedge clk);
    chk("lw101_data", read_data_out, 32'h55667788);
`endif

    // Branch redirect, taken then not taken
    @(posedge clk);
    #1;
    valid_in = 1; branch_in = 1; zero_in = 1; jump_pc_in = 32'h40;
    expq.push_back('{cyc + 1, 32'd0, 1'b0});
    #1;
    chk("br_taken", {31'b0, pc_src_out}, 32'd1);
    chk("br_target", jump_pc_out, 32'h40);
    @(posedge clk);
    #1;
    zero_in = 0;
    expq.push_back('{cyc + 1, 32'd0, 1'b0});
    #1;
    chk("br_not_taken", {31'b0, pc_src_out}, 32'd0);
    @(posedge clk);
    #1;
    clear_inputs();

    // Further patterns checked by the model only
    issue(0, 1, 0, 3'b000, 32'h201, 32'h000000A5, 0, 0, 0, st);
    issue(0, 1, 0, 3'b010, 32'h204, 32'hCAFEF00D, 0, 3, 0, st);
    issue(1, 0, 0, 3'b001, 32'h206, 0, 0, 1, 32'h80017FFF, st);
    issue(1, 0, 0, 3'b101, 32'h204, 0, 0, 0, 32'h8001F234, st);
    issue(1, 0, 0, 3'b000, 32'h200, 0, 0, 2, 32'h1122337F, st);
    issue(0, 1, 1, 3'b010, 32'h208, 32'h0BADF00D, 32'h80, 1, 0, st);
    issue(1, 0, 0, 3'b011, 32'h300, 0, 0, 0, 32'h11223344, st);
    issue(1, 1, 0, 3'b010, 32'h300, 32'h99, 0, 0, 32'h44332211, st);
    issue(0, 1, 0, 3'b001, 32'h101, 32'h0000BEEF, 0, 0, 0, st);
    issue(0, 1, 0, 3'b100, 32'h310, 32'h77, 0, 0, 0, st);
    issue(0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 0, st);
    chk("nonmem_stalls", 32'(st), 32'd0);

    // Timeout into ERROR
    hang = 1;
    hold_load(32'h300);
    rq = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_error_out) break;
      if (dmem_req) rq++;
    end
    chk("to_req_cycles", 32'(rq), 32'd15);
    chk("to_bus_error", {31'b0, bus_error_out}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("err_stall", {31'b0, stall_out}, 32'd1);
      chk("err_req", {31'b0, dmem_req}, 32'd0);
      chk("err_buserr", {31'b0, bus_error_out}, 32'd1);
    end
    #2 reset = 1;
    #1;
    chk("err_rst_buserr", {31'b0, bus_error_out}, 32'd0);
    chk("err_rst_stall", {31'b0, stall_out}, 32'd0);
    chk("err_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("err_rst_rdata", read_data_out, 32'd0);
    clear_inputs();
    hang = 0;
    @(posedge clk);
    #3 reset = 0;

    // Late ack in IDLE
    late_ack = 1;
    repeat (2) begin
      @(negedge clk);
      chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
      chk("late_ack_stall", {31'b0, stall_out}, 32'd0);
      chk("late_ack_valid", {31'b0, valid_out}, 32'd0);
    end
    late_ack = 0;
    repeat (2) @(negedge clk);

    // Reset in the middle of an access
    hang = 1;
    hold_load(32'h400);
    repeat (3) @(negedge clk);
    chk("mid_req_before", {31'b0, dmem_req}, 32'd1);
    #2 reset = 1;
    #1;
    chk("mid_req_after", {31'b0, dmem_req}, 32'd0);
    chk("mid_stall_after", {31'b0, stall_out}, 32'd0);
    clear_inputs();
    hang = 0;
    @(posedge clk);
    #3 reset = 0;
    repeat (3) @(negedge clk);

    // Normal operation after recovery
    issue(1, 0, 0, 3'b010, 32'h500, 0, 0, 1, 32'h01020304, st);
    repeat (3) @(posedge clk);
    chk("exp_drained", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
